pbit_state_histogram: RTL and testbench

//  Downstream consumer of the probabilistic network's 8 clamped output p-bits (out[0:7], e.g. product bits
//  of the 4-bit multiplier). Once per completed update sweep it samples the 8-bit output state and

---
 rtl/pbit_state_histogram.sv | 169 ++++++++++++++++
 tb/tb_pbit_state_histogram.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_state_histogram.sv
// pbit_state_histogram: per-sweep histogram of the 8 output p-bits, reporting the most frequent state.
// Revision 1.0
`default_nettype none

module pbit_state_histogram #(
  parameter int STATE_W = 8,
  parameter int CNT_W   = 16,
  parameter int NSAMP_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NSAMP_W-1:0] num_samples,
  input  logic               sample_valid,
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] rd_addr,
  output logic [CNT_W-1:0]   rd_data,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] best_state,
  output logic [CNT_W-1:0]   best_count
);

  localparam int NBINS = 2 ** STATE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_SCAN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         state, state_nxt;
  logic [CNT_W-1:0]   mem [NBINS];
  logic [CNT_W-1:0]   rdq;
  logic [STATE_W-1:0] raddr, waddr, clr_addr;
  logic [CNT_W-1:0]   wdata;
  logic               we;
  logic [STATE_W:0]   scan_cnt;
  logic               drain_cnt;
  logic [NSAMP_W-1:0] num_lat, samp_cnt;
  logic               start_ok, acc_fire;
  logic               p_valid, wb_valid;
  logic [STATE_W-1:0] p_addr, wb_addr;
  logic [CNT_W-1:0]   wb_data, inc_base, inc_val;
  logic               cmp_valid, cmp_upd;
  logic [STATE_W-1:0] cmp_addr, max_state, max_state_nxt;
  logic [CNT_W-1:0]   max_cnt, max_cnt_nxt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_nxt = S_CLEAR;
        S_CLEAR: if (clr_addr == '1) state_nxt = (num_lat == '0) ? S_DRAIN : S_ACCUM;
        S_ACCUM: if (samp_cnt == num_lat) state_nxt = S_DRAIN;
        S_DRAIN: if (drain_cnt) state_nxt = S_SCAN;
        S_SCAN:  if (scan_cnt[STATE_W]) state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state == S_CLEAR) || (state == S_ACCUM) || (state == S_DRAIN) || (state == S_SCAN);
    done = (state == S_DONE);
  end

  assign start_ok = start && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign acc_fire = (state == S_ACCUM) && sample_valid && (samp_cnt != num_lat);

  // A same-bin sample one cycle behind reads stale RAM; take the value just written instead.
  assign inc_base = (wb_valid && (wb_addr == p_addr)) ? wb_data : rdq;
  assign inc_val  = (inc_base == CNT_MAX) ? inc_base : inc_base + {{(CNT_W-1){1'b0}}, 1'b1};

  assign cmp_upd       = cmp_valid && (rdq > max_cnt);
  assign max_cnt_nxt   = cmp_upd ? rdq : max_cnt;
  assign max_state_nxt = cmp_upd ? cmp_addr : max_state;

  always_comb begin
    raddr = rd_addr;
    if (state == S_ACCUM)     raddr = state_in;
    else if (state == S_SCAN) raddr = scan_cnt[STATE_W-1:0];
  end

  always_comb begin
    we    = p_valid;
    waddr = p_addr;
    wdata = inc_val;
    if (state == S_CLEAR) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdq        <= '0;
      clr_addr   <= '0;
      scan_cnt   <= '0;
      drain_cnt  <= 1'b0;
      num_lat    <= '0;
      samp_cnt   <= '0;
      p_valid    <= 1'b0;
      p_addr     <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      cmp_valid  <= 1'b0;
      cmp_addr   <= '0;
      max_cnt    <= '0;
      max_state  <= '0;
      best_state <= '0;
      best_count <= '0;
    end else begin
      rdq       <= mem[raddr];
      p_valid   <= acc_fire;
      p_addr    <= state_in;
      wb_valid  <= p_valid;
      wb_addr   <= p_addr;
      wb_data   <= inc_val;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      scan_cnt  <= (state == S_SCAN) ? scan_cnt + {{STATE_W{1'b0}}, 1'b1} : '0;
      cmp_valid <= (state == S_SCAN) && !scan_cnt[STATE_W];
      cmp_addr  <= scan_cnt[STATE_W-1:0];
      if (start_ok) begin
        num_lat  <= num_samples;
        samp_cnt <= '0;
        clr_addr <= '0;
      end else begin
        if (state == S_CLEAR) clr_addr <= clr_addr + {{(STATE_W-1){1'b0}}, 1'b1};
        if (acc_fire)         samp_cnt <= samp_cnt + {{(NSAMP_W-1){1'b0}}, 1'b1};
      end
      if (state == S_DRAIN) begin
        max_cnt   <= '0;
        max_state <= '0;
      end else begin
        max_cnt   <= max_cnt_nxt;
        max_state <= max_state_nxt;
      end
      if ((state == S_SCAN) && (state_nxt == S_DONE)) begin
        best_state <= max_state_nxt;
        best_count <= max_cnt_nxt;
      end
    end
  end

  assign rd_data = rdq;

endmodule

`default_nettype wire

// File: tb/tb_pbit_state_histogram.sv
// Bench for pbit_state_histogram: table vectors, corner sequences and randomized runs against a histogram model.
`default_nettype none

module tb_pbit_state_histogram;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_samples = '0;
  logic        sample_valid = 1'b0;
  logic [7:0]  state_in = '0;
  logic [7:0]  rd_addr = '0;

  logic [15:0] rd_data16, best_count16;
  logic [3:0]  rd_data4, best_count4;
  logic [7:0]  best_state16, best_state4;
  logic        busy16, busy4, done16, done4;

  always #5 clk = ~clk;

  pbit_state_histogram dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .num_samples(num_samples),
    .sample_valid(sample_valid), .state_in(state_in), .rd_addr(rd_addr), .rd_data(rd_data16),
    .busy(busy16), .done(done16), .best_state(best_state16), .best_count(best_count16)
  );

  pbit_state_histogram #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .num_samples(num_samples),
    .sample_valid(sample_valid), .state_in(state_in), .rd_addr(rd_addr), .rd_data(rd_data4),
    .busy(busy4), .done(done4), .best_state(best_state4), .best_count(best_count4)
  );

  typedef struct {
    int              n;
    logic [7:0][7:0] st;
    int              gap;
    logic [7:0]      es;
    int              ec16;
    int              ec4;
  } vec_t;

  vec_t       tv[5];
  int         passed = 0;
  int         total = 0;
  int         hist[256];
  logic [7:0] sq[$];
  int         gq[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int sat(input int c, input int w);
    int m = (1 << w) - 1;
    return (c > m) ? m : c;
  endfunction

  function automatic int model_best_state(input int w);
    int bs = 0, bc = 0;
    for (int s = 0; s < 256; s++)
      if (sat(hist[s], w) > bc) begin bc = sat(hist[s], w); bs = s; end
    return bs;
  endfunction

  function automatic int model_best_count(input int w);
    int bc = 0;
    for (int s = 0; s < 256; s++)
      if (sat(hist[s], w) > bc) bc = sat(hist[s], w);
    return bc;
  endfunction

  task automatic read_bin(input logic [7:0] a, output int d16, output int d4);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d16 = int'(rd_data16);
    d4  = int'(rd_data4);
  endtask

  task automatic check_bin(input string tag, input logic [7:0] a);
    int d16, d4;
    read_bin(a, d16, d4);
    chk({tag, "_bin16"}, d16, sat(hist[a], 16));
    chk({tag, "_bin4"},  d4,  sat(hist[a], 4));
  endtask

  // Runs one histogram pass over sq/gq; only the first n entries are expected to count.
  task automatic do_run(input string tag, input int n);
    int cyc;
    for (int s = 0; s < 256; s++) hist[s] = 0;
    for (int i = 0; i < n; i++) hist[sq[i]]++;
    sq.push_back(8'hEE); gq.push_back(0);
    sq.push_back(8'hEE); gq.push_back(1);
    @(negedge clk);
    start = 1'b1;
    num_samples = n[15:0];
    @(negedge clk);
    start = 1'b0;
    sample_valid = 1'b1;
    state_in = 8'hAA;
    repeat (3) @(negedge clk);
    sample_valid = 1'b0;
    repeat (256) @(negedge clk);
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      state_in = sq[i];
      if (gq[i] > 0) begin
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (gq[i] - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, int'(done16), 1);
    chk({tag, "_done4"}, int'(done4), 1);
    chk({tag, "_busy"}, int'(busy16), 0);
  endtask

  initial begin
    int n;
    logic [7:0] pool[3];

    tv[0] = '{10, 64'h8F8F8F8F8F8F8F8F, 1, 8'h8F, 10, 10};
    tv[1] = '{5,  64'h0000000305030303, 0, 8'h03, 4,  4};
    tv[2] = '{8,  64'h0209020902090209, 1, 8'h02, 4,  4};
    tv[3] = '{0,  64'h1111111111111111, 0, 8'h00, 0,  0};
    tv[4] = '{20, 64'h0707070707070707, 0, 8'h07, 20, 15};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy16), 0);
    chk("rst_done", int'(done16), 0);
    chk("rst_best_state", int'(best_state16), 0);
    chk("rst_best_count", int'(best_count16), 0);
    chk("rst_rd_data", int'(rd_data16), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      sq.delete(); gq.delete();
      for (int i = 0; i < tv[v].n; i++) begin
        sq.push_back(tv[v].st[i % 8]);
        gq.push_back(tv[v].gap);
      end
      do_run(tag, tv[v].n);
      chk({tag, "_best_state"},  int'(best_state16), int'(tv[v].es));
      chk({tag, "_best_count"},  int'(best_count16), tv[v].ec16);
      chk({tag, "_best_state4"}, int'(best_state4),  int'(tv[v].es));
      chk({tag, "_best_count4"}, int'(best_count4),  tv[v].ec4);
      check_bin(tag, tv[v].es);
      check_bin({tag, "_ee"}, 8'hEE);
      check_bin({tag, "_aa"}, 8'hAA);
    end

    // Abort during ACCUM: back to idle, previous result kept.
    @(negedge clk);
    start = 1'b1; num_samples = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (258) @(negedge clk);
    sample_valid = 1'b1; state_in = 8'h01;
    @(negedge clk);
    sample_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy16), 0);
    chk("abort_done", int'(done16), 0);
    chk("abort_best_state", int'(best_state16), 7);
    chk("abort_best_count", int'(best_count16), 20);

    // Reset in the middle of SCAN.
    start = 1'b1; num_samples = 16'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (270) @(negedge clk);
    chk("scan_busy_before_rst", int'(busy16), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_scan_busy", int'(busy16), 0);
    chk("rst_scan_done", int'(done16), 0);
    chk("rst_scan_best_count", int'(best_count16), 0);
    @(negedge clk);
    reset_n = 1'b1;

    sq.delete(); gq.delete();
    for (int i = 0; i < 3; i++) begin sq.push_back(8'h01); gq.push_back(0); end
    do_run("post_rst", 3);
    chk("post_rst_best_state", int'(best_state16), 1);
    chk("post_rst_best_count", int'(best_count16), 3);
    check_bin("post_rst_7", 8'h07);

    // Randomized runs against the histogram model.
    for (int r = 0; r < 6; r++) begin
      string tag;
      tag = $sformatf("rnd%0d", r);
      n = int'($urandom_range(1, 40));
      for (int k = 0; k < 3; k++) pool[k] = 8'($urandom_range(0, 255));
      sq.delete(); gq.delete();
      for (int i = 0; i < n; i++) begin
        sq.push_back(pool[$urandom_range(0, 2)]);
        gq.push_back(int'($urandom_range(0, 2)));
      end
      do_run(tag, n);
      chk({tag, "_best_state"},  int'(best_state16), model_best_state(16));
      chk({tag, "_best_count"},  int'(best_count16), model_best_count(16));
      chk({tag, "_best_state4"}, int'(best_state4),  model_best_state(4));
      chk({tag, "_best_count4"}, int'(best_count4),  model_best_count(4));
      for (int k = 0; k < 3; k++) check_bin(tag, pool[k]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
